// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one registered ALU between two valid/ready requesters
// and returns each result, or an early error, on a single ID-tagged response channel.
module alu_req_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FUNC_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0_VALID,
  input  logic [DATA_WIDTH-1:0]   REQ0_A,
  input  logic [DATA_WIDTH-1:0]   REQ0_B,
  input  logic [FUNC_WIDTH-1:0]   REQ0_FUN,
  output logic                    REQ0_READY,
  input  logic                    REQ1_VALID,
  input  logic [DATA_WIDTH-1:0]   REQ1_A,
  input  logic [DATA_WIDTH-1:0]   REQ1_B,
  input  logic [FUNC_WIDTH-1:0]   REQ1_FUN,
  output logic                    REQ1_READY,
  output logic                    ALU_EN,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUNC_WIDTH-1:0]   ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VLD,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_ID,
  output logic                    RSP_ERR
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [FUNC_WIDTH-1:0] FUN_DIV = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] FUN_BAD = {FUNC_WIDTH{1'b1}};

  logic [1:0]              state;
  logic                    last_id;
  logic                    grant;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic [FUNC_WIDTH-1:0]   sel_fun;
  logic                    sel_err;
  logic                    vld_q;
  logic [2*DATA_WIDTH-1:0] out_q;

  // On contention the requester that was not served last wins; last_id resets to 1 so REQ0 leads.
  always_comb begin
    grant = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      grant = ~last_id;
    end else if (REQ1_VALID) begin
      grant = 1'b1;
    end
  end

  assign REQ0_READY = RST && (state == IDLE) && !grant && REQ0_VALID;
  assign REQ1_READY = RST && (state == IDLE) &&  grant && REQ1_VALID;
  assign xfer       = REQ0_READY || REQ1_READY;

  assign sel_a   = grant ? REQ1_A   : REQ0_A;
  assign sel_b   = grant ? REQ1_B   : REQ0_B;
  assign sel_fun = grant ? REQ1_FUN : REQ0_FUN;
  assign sel_err = ((sel_fun == FUN_DIV) && (sel_b == '0)) || (sel_fun == FUN_BAD);

  // The ALU result passes through a retiming stage that only arms while waiting,
  // so a stray ALU_VLD outside WAIT can never be mistaken for the current result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      vld_q     <= 1'b0;
      out_q     <= '0;
      ALU_EN    <= 1'b0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ID    <= 1'b0;
      RSP_ERR   <= 1'b0;
    end else begin
      vld_q  <= ALU_VLD && (state == WAIT);
      out_q  <= ALU_OUT;
      ALU_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            last_id <= grant;
            RSP_ID  <= grant;
            if (sel_err) begin
              state     <= RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b1;
              RSP_DATA  <= '0;
            end else begin
              state   <= ISSUE;
              ALU_EN  <= 1'b1;
              ALU_A   <= sel_a;
              ALU_B   <= sel_b;
              ALU_FUN <= sel_fun;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (vld_q) begin
            state     <= RESP;
            RSP_VALID <= 1'b1;
            RSP_DATA  <= out_q;
            RSP_ERR   <= 1'b0;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            state     <= IDLE;
            RSP_VALID <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a small registered ALU model sits behind the arbiter
// and every expected response value is a hand-computed constant.
module tb_alu_req_arbiter;

  logic        CLK;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic [7:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]  REQ0_FUN, REQ1_FUN;
  logic        REQ0_READY, REQ1_READY;
  logic        ALU_EN;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_VLD;
  logic        RSP_VALID, RSP_READY;
  logic [15:0] RSP_DATA;
  logic        RSP_ID, RSP_ERR;

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  int en_before;
  logic [17:0] ct_exp [4];

  alu_req_arbiter #(.DATA_WIDTH(8), .FUNC_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .REQ1_READY(REQ1_READY),
    .ALU_EN(ALU_EN), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_VLD(ALU_VLD),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_ID(RSP_ID), .RSP_ERR(RSP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ALU: one cycle from ALU_EN to a single-cycle ALU_VLD pulse.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_VLD <= 1'b0;
      ALU_OUT <= 16'd0;
    end else begin
      ALU_VLD <= ALU_EN;
      if (ALU_EN) begin
        case (ALU_FUN)
          4'd0:    ALU_OUT <= 16'(ALU_A) + 16'(ALU_B);
          4'd1:    ALU_OUT <= 16'(ALU_A) - 16'(ALU_B);
          4'd2:    ALU_OUT <= 16'(ALU_A) * 16'(ALU_B);
          4'd3:    ALU_OUT <= (ALU_B != 8'd0) ? 16'(ALU_A / ALU_B) : 16'd0;
          default: ALU_OUT <= 16'd0;
        endcase
      end
    end
  end

  always @(posedge CLK) begin
    if (RST && ALU_EN) en_count <= en_count + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!RSP_VALID && n < 20) begin
      step();
      n++;
    end
    check_output({tag, "_rsp_arrives"}, 32'(RSP_VALID), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST = 1'b0;
    REQ0_VALID = 1'b0; REQ0_A = 8'd0; REQ0_B = 8'd0; REQ0_FUN = 4'd0;
    REQ1_VALID = 1'b0; REQ1_A = 8'd0; REQ1_B = 8'd0; REQ1_FUN = 4'd0;
    RSP_READY = 1'b0;
    ct_exp[0] = {1'b0, 1'b0, 16'd255};
    ct_exp[1] = {1'b0, 1'b1, 16'd42};
    ct_exp[2] = {1'b0, 1'b0, 16'd255};
    ct_exp[3] = {1'b0, 1'b1, 16'd42};

    // Reset state
    REQ0_VALID = 1'b1;
    #2;
    check_output("rst_req0_ready", 32'(REQ0_READY), 32'd0);
    check_output("rst_alu", 32'({ALU_EN, ALU_A, ALU_B, ALU_FUN}), 32'd0);
    check_output("rst_rsp", 32'({RSP_VALID, RSP_ERR, RSP_ID, RSP_DATA}), 32'd0);
    REQ0_VALID = 1'b0;
    step(); step();
    RST = 1'b1;

    // Single ADD from requester 0
    REQ0_A = 8'd20; REQ0_B = 8'd22; REQ0_FUN = 4'd0; REQ0_VALID = 1'b1;
    #1;
    check_output("add_ready", 32'({REQ0_READY, REQ1_READY}), 32'b10);
    en_before = en_count;
    step();
    REQ0_VALID = 1'b0; REQ0_A = 8'hEE;
    check_output("add_issue", 32'({ALU_EN, ALU_A, ALU_B, ALU_FUN}), 32'({1'b1, 8'd20, 8'd22, 4'd0}));
    step();
    check_output("add_en_drop", 32'(ALU_EN), 32'd0);
    step();
    check_output("add_rsp_early", 32'(RSP_VALID), 32'd0);
    step();
    check_output("add_rsp", 32'({RSP_VALID, RSP_ERR, RSP_ID, RSP_DATA}), 32'({1'b1, 1'b0, 1'b0, 16'd42}));
    check_output("add_en_pulses", 32'(en_count - en_before), 32'd1);
    RSP_READY = 1'b1;
    step();
    check_output("add_rsp_done", 32'(RSP_VALID), 32'd0);
    RSP_READY = 1'b0;

    // Divide-by-zero from requester 1
    REQ1_A = 8'd9; REQ1_B = 8'd0; REQ1_FUN = 4'd3; REQ1_VALID = 1'b1;
    #1;
    check_output("dz_ready", 32'({REQ0_READY, REQ1_READY}), 32'b01);
    en_before = en_count;
    step();
    REQ1_VALID = 1'b0;
    check_output("dz_rsp", 32'({RSP_VALID, RSP_ERR, RSP_ID, RSP_DATA}), 32'({1'b1, 1'b1, 1'b1, 16'd0}));
    check_output("dz_alu_en", 32'(ALU_EN), 32'd0);
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
    check_output("dz_done", 32'(RSP_VALID), 32'd0);
    check_output("dz_en_pulses", 32'(en_count - en_before), 32'd0);
    check_output("dz_alu_hold", 32'({ALU_A, ALU_B, ALU_FUN}), 32'({8'd20, 8'd22, 4'd0}));

    // Contention: both valid continuously, grants alternate 0,1,0,1
    REQ0_A = 8'd15; REQ0_B = 8'd17; REQ0_FUN = 4'd2; REQ0_VALID = 1'b1;
    REQ1_A = 8'd50; REQ1_B = 8'd8;  REQ1_FUN = 4'd1; REQ1_VALID = 1'b1;
    RSP_READY = 1'b1;
    #1;
    check_output("ct_first_grant", 32'({REQ0_READY, REQ1_READY}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      wait_rsp($sformatf("ct%0d", i));
      check_output($sformatf("ct_rsp%0d", i), 32'({RSP_ERR, RSP_ID, RSP_DATA}), 32'(ct_exp[i]));
      step();
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RSP_READY = 1'b0;

    // Backpressure on a DIV 100/7
    REQ0_A = 8'd100; REQ0_B = 8'd7; REQ0_FUN = 4'd3; REQ0_VALID = 1'b1;
    #1;
    check_output("bp_ready", 32'(REQ0_READY), 32'd1);
    step();
    REQ0_VALID = 1'b0;
    wait_rsp("bp");
    check_output("bp_data", 32'(RSP_DATA), 32'd14);
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output($sformatf("bp_hold%0d", i), 32'({RSP_VALID, RSP_ERR, RSP_ID, RSP_DATA}),
                   32'({1'b1, 1'b0, 1'b0, 16'd14}));
      check_output($sformatf("bp_ready%0d", i), 32'({REQ0_READY, REQ1_READY}), 32'b00);
    end
    RSP_READY = 1'b1;
    #1;
    check_output("bp_ready_same_cycle", 32'({REQ0_READY, REQ1_READY}), 32'b00);
    step();
    check_output("bp_released", 32'(RSP_VALID), 32'd0);
    check_output("bp_next_grant", 32'({REQ0_READY, REQ1_READY}), 32'b01);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RSP_READY = 1'b0;

    // Illegal function code
    REQ0_A = 8'd3; REQ0_B = 8'd4; REQ0_FUN = 4'hF; REQ0_VALID = 1'b1;
    #1;
    check_output("il_ready", 32'(REQ0_READY), 32'd1);
    en_before = en_count;
    step();
    REQ0_VALID = 1'b0;
    check_output("il_rsp", 32'({RSP_VALID, RSP_ERR, RSP_ID, RSP_DATA}), 32'({1'b1, 1'b1, 1'b0, 16'd0}));
    check_output("il_alu_en", 32'(ALU_EN), 32'd0);
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
    check_output("il_en_pulses", 32'(en_count - en_before), 32'd0);
    check_output("il_alu_hold", 32'({ALU_A, ALU_B, ALU_FUN}), 32'({8'd100, 8'd7, 4'd3}));

    // Reset in WAIT, then REQ0 priority after release
    REQ1_A = 8'd1; REQ1_B = 8'd2; REQ1_FUN = 4'd0; REQ1_VALID = 1'b1;
    step();
    REQ1_VALID = 1'b0;
    check_output("rm_issue", 32'(ALU_EN), 32'd1);
    step();
    RST = 1'b0;
    #1;
    check_output("rm_rst_alu", 32'({ALU_EN, ALU_A, ALU_B, ALU_FUN}), 32'd0);
    check_output("rm_rst_rsp", 32'({RSP_VALID, RSP_DATA}), 32'd0);
    step(); step();
    RST = 1'b1;
    REQ0_A = 8'd1;  REQ0_B = 8'd2; REQ0_FUN = 4'd0; REQ0_VALID = 1'b1;
    REQ1_A = 8'd50; REQ1_B = 8'd8; REQ1_FUN = 4'd1; REQ1_VALID = 1'b1;
    RSP_READY = 1'b1;
    #1;
    check_output("rm_prio", 32'({REQ0_READY, REQ1_READY}), 32'b10);
    step();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    wait_rsp("rm");
    check_output("rm_rsp", 32'({RSP_ERR, RSP_ID, RSP_DATA}), 32'({1'b0, 1'b0, 16'd3}));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
